vga_timing_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 VGA controller.
- Generates hsync/vsync/valid from configurable horizontal and vertical timing, with configurable sync polarity.
- Provides pixel coordinates plus character-cell coordinates for any cell size, using sub-counters instead of dividers.
- Delays sync/valid by a configurable pipeline depth so they line up with vga_data from a latent frame/char buffer. Sits between the pixel-source logic and the VGA DAC pins.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_delay_line.sv | 31 +++
 rtl/vga_timing_gen.sv | 160 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and types for the parametrised timing generator.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam bit POL_LOW  = 1'b0;
  localparam bit POL_HIGH = 1'b1;

  localparam int unsigned CELL_W_DEF = 9;
  localparam int unsigned CELL_H_DEF = 16;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic valid;
  } vga_ctl_t;

  function automatic int unsigned timing_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register pipe with enable; depth 0 degenerates to a wire.
module vga_delay_line #(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else if (en) begin
        stage[0] <= din;
        for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel/cell addressing, delayed sync/valid
// aligned to a latent pixel source, and blanked colour outputs.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = VGA_H_ACTIVE,
  parameter int unsigned H_FP         = VGA_H_FP,
  parameter int unsigned H_SYNC       = VGA_H_SYNC,
  parameter int unsigned H_BP         = VGA_H_BP,
  parameter int unsigned V_ACTIVE     = VGA_V_ACTIVE,
  parameter int unsigned V_FP         = VGA_V_FP,
  parameter int unsigned V_SYNC       = VGA_V_SYNC,
  parameter int unsigned V_BP         = VGA_V_BP,
  parameter bit          HS_POL       = POL_LOW,
  parameter bit          VS_POL       = POL_LOW,
  parameter int unsigned CELL_W       = CELL_W_DEF,
  parameter int unsigned CELL_H       = CELL_H_DEF,
  parameter int unsigned DATA_LATENCY = 1,
  parameter int unsigned COLOR_W      = 8
) (
  input  logic                 pclk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [3*COLOR_W-1:0] vga_data,
  output logic [9:0]           h_addr,
  output logic [9:0]           v_addr,
  output logic [6:0]           x_addr,
  output logic [4:0]           y_addr,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 valid,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 frame_start
);

  localparam int unsigned H_TOTAL  = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL  = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned CXW      = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int unsigned CYW      = (CELL_H > 1) ? $clog2(CELL_H) : 1;

  if (H_ACTIVE / CELL_W > 127) begin : g_chk_x
    $error("H_ACTIVE/CELL_W does not fit the 7-bit x_addr");
  end
  if (V_ACTIVE / CELL_H > 31) begin : g_chk_y
    $error("V_ACTIVE/CELL_H does not fit the 5-bit y_addr");
  end
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_chk_tot
    $error("line/frame totals exceed the 10-bit counters");
  end
  if (DATA_LATENCY > 7) begin : g_chk_lat
    $error("DATA_LATENCY must be in 0..7");
  end

  logic [9:0]     h_cnt, v_cnt;
  logic [CXW-1:0] cx_sub;
  logic [CYW-1:0] cy_sub;
  logic [6:0]     x_cell;
  logic [4:0]     y_cell;
  logic           h_wrap, v_wrap, h_active, v_active;
  vga_ctl_t       ctl_int, ctl_dly;

  always_comb begin
    h_wrap   = (32'(h_cnt) == H_TOTAL - 1);
    v_wrap   = (32'(v_cnt) == V_TOTAL - 1);
    h_active = (32'(h_cnt) < H_ACTIVE);
    v_active = (32'(v_cnt) < V_ACTIVE);
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Cell coordinates tracked by sub-counters so no divider is needed.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      cx_sub <= '0;
      x_cell <= '0;
    end else if (en) begin
      if (h_wrap) begin
        cx_sub <= '0;
        x_cell <= '0;
      end else if (h_active) begin
        if (32'(cx_sub) == CELL_W - 1) begin
          cx_sub <= '0;
          x_cell <= x_cell + 7'd1;
        end else begin
          cx_sub <= cx_sub + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      cy_sub <= '0;
      y_cell <= '0;
    end else if (en && h_wrap) begin
      if (v_wrap) begin
        cy_sub <= '0;
        y_cell <= '0;
      end else if (v_active) begin
        if (32'(cy_sub) == CELL_H - 1) begin
          cy_sub <= '0;
          y_cell <= y_cell + 5'd1;
        end else begin
          cy_sub <= cy_sub + 1'b1;
        end
      end
    end
  end

  always_comb begin
    h_addr        = h_active ? h_cnt : '0;
    v_addr        = v_active ? v_cnt : '0;
    x_addr        = h_active ? x_cell : '0;
    y_addr        = v_active ? y_cell : '0;
    frame_start   = en && (h_cnt == '0) && (v_cnt == '0);
    ctl_int.hsync = (32'(h_cnt) >= HS_START && 32'(h_cnt) < HS_END) ? HS_POL : ~HS_POL;
    ctl_int.vsync = (32'(v_cnt) >= VS_START && 32'(v_cnt) < VS_END) ? VS_POL : ~VS_POL;
    ctl_int.valid = h_active && v_active;
  end

  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (DATA_LATENCY),
    .RST_VAL ({~HS_POL, ~VS_POL, 1'b0})
  ) u_ctl_dly (
    .pclk  (pclk),
    .reset (reset),
    .en    (en),
    .din   (ctl_int),
    .dout  (ctl_dly)
  );

  always_comb begin
    hsync = ctl_dly.hsync;
    vsync = ctl_dly.vsync;
    valid = ctl_dly.valid;
    vga_r = valid ? vga_data[3*COLOR_W-1 -: COLOR_W] : '0;
    vga_g = valid ? vga_data[2*COLOR_W-1 -: COLOR_W] : '0;
    vga_b = valid ? vga_data[COLOR_W-1 -: COLOR_W]   : '0;
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench: three timing configurations checked every cycle against a
// closed-form model driven only by the count of enabled clock edges.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, hp, vp, cw, ch, lat;
  } cfg_t;

  logic        pclk = 1'b0;
  logic        reset;
  logic        en;
  logic [23:0] vga_data;
  logic [59:0] vec_a, vec_b, vec_c;
  cfg_t        cfg_a, cfg_b, cfg_c;
  int          n;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 pclk = ~pclk;

  // A: full defaults. B: default line, short frame, pass-through pipe.
  // C: small timing, active-high syncs, odd cells, latency 2.
  logic [9:0] ha_a, va_a, ha_b, va_b, ha_c, va_c;
  logic [6:0] xa_a, xa_b, xa_c;
  logic [4:0] ya_a, ya_b, ya_c;
  logic       hs_a, vs_a, vl_a, fs_a, hs_b, vs_b, vl_b, fs_b, hs_c, vs_c, vl_c, fs_c;
  logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;

  vga_timing_gen u_a (
    .pclk(pclk), .reset(reset), .en(en), .vga_data(vga_data),
    .h_addr(ha_a), .v_addr(va_a), .x_addr(xa_a), .y_addr(ya_a),
    .hsync(hs_a), .vsync(vs_a), .valid(vl_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(3), .DATA_LATENCY(0)
  ) u_b (
    .pclk(pclk), .reset(reset), .en(en), .vga_data(vga_data),
    .h_addr(ha_b), .v_addr(va_b), .x_addr(xa_b), .y_addr(ya_b),
    .hsync(hs_b), .vsync(vs_b), .valid(vl_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .frame_start(fs_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(40), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(18), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b1), .CELL_W(7), .CELL_H(5), .DATA_LATENCY(2)
  ) u_c (
    .pclk(pclk), .reset(reset), .en(en), .vga_data(vga_data),
    .h_addr(ha_c), .v_addr(va_c), .x_addr(xa_c), .y_addr(ya_c),
    .hsync(hs_c), .vsync(vs_c), .valid(vl_c),
    .vga_r(r_c), .vga_g(g_c), .vga_b(b_c), .frame_start(fs_c)
  );

  assign vec_a = {ha_a, va_a, xa_a, ya_a, hs_a, vs_a, vl_a, r_a, g_a, b_a, fs_a};
  assign vec_b = {ha_b, va_b, xa_b, ya_b, hs_b, vs_b, vl_b, r_b, g_b, b_b, fs_b};
  assign vec_c = {ha_c, va_c, xa_c, ya_c, hs_c, vs_c, vl_c, r_c, g_c, b_c, fs_c};

  // Expected outputs after n enabled edges since reset.
  function automatic logic [59:0] model(input cfg_t c, input int cnt,
                                        input logic en_now, input logic [23:0] d);
    int ht, vt, h, v, m, hd, vd;
    logic [9:0] ho, vo;
    logic [6:0] xo;
    logic [4:0] yo;
    logic hs, vs, val, fs;
    logic [23:0] rgb;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    h  = cnt % ht;
    v  = (cnt / ht) % vt;
    ho = (h < c.ha) ? 10'(h) : 10'd0;
    vo = (v < c.va) ? 10'(v) : 10'd0;
    xo = (h < c.ha) ? 7'(h / c.cw) : 7'd0;
    yo = (v < c.va) ? 5'(v / c.ch) : 5'd0;
    m  = cnt - c.lat;
    if (m < 0) begin
      hs  = (c.hp == 0);
      vs  = (c.vp == 0);
      val = 1'b0;
    end else begin
      hd  = m % ht;
      vd  = (m / ht) % vt;
      hs  = (hd >= c.ha + c.hf && hd < c.ha + c.hf + c.hs) ? (c.hp != 0) : (c.hp == 0);
      vs  = (vd >= c.va + c.vf && vd < c.va + c.vf + c.vs) ? (c.vp != 0) : (c.vp == 0);
      val = (hd < c.ha) && (vd < c.va);
    end
    rgb = val ? d : 24'd0;
    fs  = en_now && (h == 0) && (v == 0);
    return {ho, vo, xo, yo, hs, vs, val, rgb, fs};
  endfunction

  task automatic check_eq(input string tag, input logic [59:0] got, input logic [59:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s n=%0d t=%0t got=%h exp=%h", tag, n, $time, got, exp);
    end
  endtask

  task automatic check_all();
    check_eq("cfg_a", vec_a, model(cfg_a, n, en, vga_data));
    check_eq("cfg_b", vec_b, model(cfg_b, n, en, vga_data));
    check_eq("cfg_c", vec_c, model(cfg_c, n, en, vga_data));
  endtask

  task automatic step(input logic en_next, input logic [23:0] d_next);
    @(posedge pclk);
    if (en && !reset) n++;
    #1;
    en       = en_next;
    vga_data = d_next;
    #1;
    check_all();
  endtask

  function automatic logic rand_en();
    return ($urandom_range(31) != 0);
  endfunction

  initial begin
    int guard;
    cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 9, 16, 1};
    cfg_b = '{640, 16, 96, 48, 40, 2, 2, 3, 0, 0, 9, 16, 0};
    cfg_c = '{40, 3, 5, 4, 18, 2, 2, 3, 1, 1, 7, 5, 2};
    n        = 0;
    reset    = 1'b1;
    en       = 1'b0;
    vga_data = '0;
    #2;
    check_all();
    for (int i = 0; i < 3; i++) step(1'b1, $urandom);
    reset = 1'b0;

    for (int i = 0; i < 30000; i++) step(rand_en(), $urandom);

    // Freeze the line at h_cnt=300 of cfg_a for 50 cycles.
    guard = 0;
    while (((n + 1) % 800) != 300 && guard < 2000) begin
      step(1'b1, $urandom);
      guard++;
    end
    if (guard >= 2000) begin
      n_err++;
      $display("FAIL freeze_wait guard=%0d limit=%0d", guard, 2000);
    end
    for (int i = 0; i < 50; i++) step(1'b0, 24'hFFFFFF);
    for (int i = 0; i < 15000; i++) step(rand_en(), $urandom);

    // Asynchronous reset mid-line at h_cnt=400 of cfg_a.
    guard = 0;
    while ((n % 800) != 400 && guard < 2000) begin
      step(1'b1, $urandom);
      guard++;
    end
    if (guard >= 2000) begin
      n_err++;
      $display("FAIL reset_wait guard=%0d limit=%0d", guard, 2000);
    end
    reset = 1'b1;
    #1;
    n = 0;
    check_all();
    for (int i = 0; i < 3; i++) step(1'b1, $urandom);
    reset = 1'b0;
    for (int i = 0; i < 2000; i++) step(rand_en(), $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
